drum_rr_sched: RTL and testbench
================================

// Module: drum_rr_sched
// PURPOSE
// - Shares one DRUM approximate multiplier (drum, k/n/m) among NREQ requesters.
// - Round-robin grant, one operand pair latched per grant, registered result
//   returned with requester ID over a valid/ready response channel.
// - Sits between host-side operand sources (RAM/IO front end) and the single
//   drum datapath instance, so the multiplier is never duplicated.
// PARAMETERS
// - K     3  DRUM truncation width passed to drum
// - N     8  operand A width
// - M     8  operand B width
// - NREQ  4  number of requesters (2..8)
// PORTS
// - clk        in   1          clock, all state on rising edge
// - rst_n      in   1          reset, asynchronous, active-low
// - req_valid  in   NREQ       per-requester operand valid
// - req_ready  out  NREQ       per-requester accept (one-hot or zero)
// - req_a      in   NREQ*N     packed operand A, slice i = requester i
// - req_b      in   NREQ*M     packed operand B, slice i = requester i
// - rsp_valid  out  1          result valid
// - rsp_ready  in   1          result consumer ready
// - rsp_id     out  clog2(NREQ) requester index of result
// - rsp_r      out  N+M        drum(a,b) result, bit-exact to drum module
// - busy       out  1          state != IDLE
// - op_count   out  16         completed responses, saturates at 0xFFFF
// BEHAVIOUR
// - Reset (async assert, sync-released use): state=IDLE, rsp_valid=0, rsp_id=0,
//   rsp_r=0, op_count=0, last_grant=NREQ-1 (requester 0 has first priority).
// - FSM states IDLE, MUL, RESP.
// - IDLE: if |req_valid, grant = first valid index searching last_grant+1 ..
//   wrapping mod NREQ; req_ready[grant]=1 combinationally this cycle only;
//   latch a_q, b_q, id_q; last_grant<=grant; -> MUL. Else stay, req_ready=0.
// - MUL: drum driven from a_q/b_q; rsp_r<=r, rsp_id<=id_q, rsp_valid<=1; -> RESP.
// - RESP: hold rsp_* stable while rsp_ready=0. On rsp_ready=1: op_count++ (sat);
//   if |req_valid, accept next grant same cycle (as IDLE) -> MUL, rsp_valid<=0;
//   else rsp_valid<=0 -> IDLE.
// - Latency: accept at cycle T -> rsp_valid=1 at T+2. Peak throughput 1 per 2.
// - req_ready only asserted for a requester whose req_valid=1; zero in MUL and
//   in RESP while rsp_ready=0. Requesters must hold valid/data until ready.
// - Valid dropped before grant: simply not considered; no error.
// - Single requester active: served back-to-back, no idle bubble beyond MUL.
// - op_count at 0xFFFF stays 0xFFFF.
// - Reset mid-operation: in-flight operands/result discarded, no response.
// - Widths: rsp_r exactly N+M bits, no extension; sign handling is drum's
//   (one's-complement invert on operand MSB), not corrected here.
// STRUCTURE
// - Package drum_sched_pkg: state enum {IDLE, MUL, RESP}, ID width function
//   clog2(NREQ), OPCNT_W=16.
// - Sub-module rr_pick (NREQ): inputs valid vector, last_grant; outputs
//   grant index + any flag; purely combinational, rotate-then-priority.
// - One drum instance (K,N,M); top holds FSM, operand/result regs, counter.
// TESTING
// - Reset: rst_n=0 mid-RESP -> rsp_valid=0, busy=0, op_count=0 immediately.
// - Exact path: req0 a=5,b=6, rsp_ready=1 -> T+2 rsp_valid, rsp_id=0,
//   rsp_r=0x001E; op_count=1.
// - Approx path: req2 a=100,b=3 -> rsp_r=0x0150 (336, exact 300), rsp_id=2.
// - Sign path: a=0xFF,b=3 -> rsp_r=0xFFFF.
// - Fairness: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0;
//   one response every 2 cycles; op_count=5 after 5 responses.
// - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0;
//   then rsp_ready=1 with req1 valid -> req_ready[1] same cycle, next rsp at +2.

Source files
------------

// File: rtl/drum_sched_pkg.sv
// Shared types and sizing helpers for the round-robin DRUM multiplier scheduler.
package drum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    localparam int OPCNT_W = 16;

    // A single requester still needs a one-bit ID field
    function automatic int id_width(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/drum_rr_sched_if.sv
// Request/response bundle between host-side operand sources and the scheduler.
interface drum_rr_sched_if
    import drum_sched_pkg::*;
#(
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*M-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [N+M-1:0]    rsp_r;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_r
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_r
    );

endinterface

// File: rtl/drum.sv
// DRUM approximate multiplier: keep K bits from each operand's leading one,
// force the kept LSB high to unbias, multiply, then shift back.
module drum #(
    parameter int K = 3,
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic [N+M-1:0] r
);

    logic [N-1:0]   a_abs;
    logic [M-1:0]   b_abs;
    logic [K-1:0]   a_t;
    logic [K-1:0]   b_t;
    logic [2*K-1:0] prod;
    logic [N+M-1:0] mag;
    int             lead_a;
    int             lead_b;
    int             sh_a;
    int             sh_b;

    // Negative operands are one's-complemented, and so is the result
    always_comb begin
        a_abs  = a[N-1] ? ~a : a;
        lead_a = 0;
        for (int i = 0; i < N; i++) begin
            if (a_abs[i]) lead_a = i;
        end
        if (lead_a < K) begin
            sh_a = 0;
            a_t  = a_abs[K-1:0];
        end else begin
            sh_a   = lead_a - K + 1;
            a_t    = K'(a_abs >> sh_a);
            a_t[0] = 1'b1;
        end
    end

    always_comb begin
        b_abs  = b[M-1] ? ~b : b;
        lead_b = 0;
        for (int i = 0; i < M; i++) begin
            if (b_abs[i]) lead_b = i;
        end
        if (lead_b < K) begin
            sh_b = 0;
            b_t  = b_abs[K-1:0];
        end else begin
            sh_b   = lead_b - K + 1;
            b_t    = K'(b_abs >> sh_b);
            b_t[0] = 1'b1;
        end
    end

    assign prod = (2*K)'(a_t) * (2*K)'(b_t);
    assign mag  = (N+M)'(prod) << (sh_a + sh_b);
    assign r    = (a[N-1] ^ b[M-1]) ? ~mag : mag;

endmodule

// File: rtl/drum_rr_sched_rr_pick.sv
// Round-robin picker: rotate the valid vector to start just past the last
// grant, take the lowest set bit, then rotate the index back.
module rr_pick
    import drum_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] grant,
    output logic            any
);

    logic [ID_W-1:0]   start;
    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [ID_W-1:0]   offset;
    logic [ID_W:0]     sum;

    assign start   = (last_grant == ID_W'(NREQ-1)) ? '0 : last_grant + ID_W'(1);
    assign doubled = {valid, valid} >> start;
    assign rotated = doubled[NREQ-1:0];
    assign any     = |valid;

    always_comb begin
        offset = '0;
        for (int j = NREQ-1; j >= 0; j--) begin
            if (rotated[j]) offset = ID_W'(j);
        end
    end

    assign sum   = {1'b0, start} + {1'b0, offset};
    assign grant = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ)) : sum[ID_W-1:0];

endmodule

// File: rtl/drum_rr_sched.sv
// Shares one DRUM multiplier among NREQ requesters with round-robin grants
// and a registered valid/ready response carrying the requester ID.
module drum_rr_sched
    import drum_sched_pkg::*;
#(
    parameter int K    = 3,
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    drum_rr_sched_if.slave     bus,
    output logic               busy,
    output logic [OPCNT_W-1:0] op_count
);

    localparam int ID_W = id_width(NREQ);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            any_valid;
    logic            accept;
    logic [NREQ-1:0] req_ready_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    a_sel;
    logic [M-1:0]    b_q;
    logic [M-1:0]    b_sel;
    logic [N+M-1:0]  mul_r;
    logic [N+M-1:0]  rsp_r_q;
    logic            rsp_valid_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any_valid)
    );

    drum #(.K(K), .N(N), .M(M)) u_drum (
        .a (a_q),
        .b (b_q),
        .r (mul_r)
    );

    assign a_sel = bus.req_a[grant*N +: N];
    assign b_sel = bus.req_b[grant*M +: M];

    // A new grant is possible when idle, or when the pending response drains this cycle
    assign accept = any_valid && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

    always_comb begin
        req_ready_d = '0;
        if (accept) req_ready_d[grant] = 1'b1;
    end

    assign bus.req_ready = req_ready_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_r     = rsp_r_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NREQ-1);
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                a_q        <= a_sel;
                b_q        <= b_sel;
                id_q       <= grant;
                last_grant <= grant;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= MUL;
                end
                MUL: begin
                    rsp_r_q     <= mul_r;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (op_count != '1) op_count <= op_count + OPCNT_W'(1);
                        state <= any_valid ? MUL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_rr_sched.sv
// Directed bench for drum_rr_sched: reset, exact/approx/sign products,
// round-robin fairness and response backpressure.
module tb_drum_rr_sched;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_count;
    int          n_cmp;
    int          n_err;

    drum_rr_sched_if #(.N(8), .M(8), .NREQ(4)) bus ();

    drum_rr_sched #(.K(3), .N(8), .M(8), .NREQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("[TB] FAIL reset_count got=%0d exp=0", op_count); end
        n_cmp++; if (bus.rsp_r !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_r got=%h exp=0000", bus.rsp_r); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_id got=%0d exp=0", bus.rsp_id); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exact();
        bus.rsp_ready  = 1'b1;
        bus.req_a[7:0] = 8'd5;
        bus.req_b[7:0] = 8'd6;
        bus.req_valid  = 4'b0001;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL exact_ready got=%b exp=0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL exact_busy got=%b exp=1", busy); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL exact_early got=%b exp=0", bus.rsp_valid); end
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL exact_valid got=%b exp=1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("[TB] FAIL exact_id got=%0d exp=0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_r !== 16'h001E) begin n_err++; $display("[TB] FAIL exact_r got=%h exp=001e", bus.rsp_r); end
        step();
        n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("[TB] FAIL exact_count got=%0d exp=1", op_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL exact_idle got=%b exp=0", busy); end
    endtask

    task automatic test_approx();
        bus.req_a[23:16] = 8'd100;
        bus.req_b[23:16] = 8'd3;
        bus.req_valid    = 4'b0100;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL approx_ready got=%b exp=0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        n_cmp++; if (bus.rsp_id !== 2'd2) begin n_err++; $display("[TB] FAIL approx_id got=%0d exp=2", bus.rsp_id); end
        n_cmp++; if (bus.rsp_r !== 16'h0150) begin n_err++; $display("[TB] FAIL approx_r got=%h exp=0150", bus.rsp_r); end
        step();
        n_cmp++; if (op_count !== 16'd2) begin n_err++; $display("[TB] FAIL approx_count got=%0d exp=2", op_count); end
    endtask

    task automatic test_sign();
        bus.req_a[31:24] = 8'hFF;
        bus.req_b[31:24] = 8'd3;
        bus.req_valid    = 4'b1000;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL sign_ready got=%b exp=1000", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        n_cmp++; if (bus.rsp_id !== 2'd3) begin n_err++; $display("[TB] FAIL sign_id got=%0d exp=3", bus.rsp_id); end
        n_cmp++; if (bus.rsp_r !== 16'hFFFF) begin n_err++; $display("[TB] FAIL sign_r got=%h exp=ffff", bus.rsp_r); end
        step();
        n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("[TB] FAIL sign_count got=%0d exp=3", op_count); end
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready    = 1'b0;
        bus.req_a[15:8]  = 8'd5;
        bus.req_b[15:8]  = 8'd6;
        bus.req_valid    = 4'b0010;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("[TB] FAIL midrst_ready got=%b exp=0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_pending got=%b exp=1", bus.rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("[TB] FAIL midrst_count got=%0d exp=0", op_count); end
        step();
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_norsp got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_id [5];
        logic [15:0] exp_r  [5];
        exp_id = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        exp_r  = '{16'd7, 16'd14, 16'd21, 16'd28, 16'd7};
        bus.req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.req_b     = {8'd7, 8'd7, 8'd7, 8'd7};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n_cmp++; if (bus.req_ready !== (4'b0001 << exp_id[g])) begin n_err++; $display("[TB] FAIL fair_ready[%0d] got=%b exp=%b", g, bus.req_ready, 4'b0001 << exp_id[g]); end
            step();
            n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL fair_mul[%0d] got valid=%b ready=%b exp 0/0000", g, bus.rsp_valid, bus.req_ready); end
            step();
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL fair_valid[%0d] got=%b exp=1", g, bus.rsp_valid); end
            n_cmp++; if (bus.rsp_id !== exp_id[g][1:0]) begin n_err++; $display("[TB] FAIL fair_id[%0d] got=%0d exp=%0d", g, bus.rsp_id, exp_id[g]); end
            n_cmp++; if (bus.rsp_r !== exp_r[g]) begin n_err++; $display("[TB] FAIL fair_r[%0d] got=%h exp=%h", g, bus.rsp_r, exp_r[g]); end
        end
        bus.req_valid = '0;
        step();
        n_cmp++; if (op_count !== 16'd5) begin n_err++; $display("[TB] FAIL fair_count got=%0d exp=5", op_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL fair_idle got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready    = 1'b0;
        bus.req_a[23:16] = 8'd100;
        bus.req_b[23:16] = 8'd3;
        bus.req_valid    = 4'b0100;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL bp_first_ready got=%b exp=0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        bus.req_a[15:8] = 8'd5;
        bus.req_b[15:8] = 8'd6;
        bus.req_valid   = 4'b0010;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_r !== 16'h0150) begin n_err++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d r=%h exp v=1 id=2 r=0150", c, bus.rsp_valid, bus.rsp_id, bus.rsp_r); end
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=0000", c, bus.req_ready); end
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("[TB] FAIL bp_release_ready got=%b exp=0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        n_cmp++; if (op_count !== 16'd6) begin n_err++; $display("[TB] FAIL bp_count1 got=%0d exp=6", op_count); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drop got=%b exp=0", bus.rsp_valid); end
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_r !== 16'h001E) begin n_err++; $display("[TB] FAIL bp_next got v=%b id=%0d r=%h exp v=1 id=1 r=001e", bus.rsp_valid, bus.rsp_id, bus.rsp_r); end
        step();
        n_cmp++; if (op_count !== 16'd7) begin n_err++; $display("[TB] FAIL bp_count2 got=%0d exp=7", op_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_exact();
        test_approx();
        test_sign();
        test_reset_mid();
        test_fairness();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
